noc_input_buffer: RTL and testbench
===================================

// Module: noc_input_buffer
// PURPOSE
//  Per-port input FIFO of the NoC router; sits directly upstream of the round-robin arbiter / switch control.
//  Stores incoming flits and raises o_h (the arbiter's i_requests bit for this port) when a packet header is at the head.
//  Releases header, size and payload flits to the crossbar once the header is granted.
//  Packet format: flit0 = header (target address), flit1 = size N (payload flit count), then N payload flits.
// PARAMETERS
//  FLIT_WIDTH    16  width of one flit in bits
//  BUFFER_DEPTH  16  FIFO entries; power of two, >= 4
// PORTS
//  i_clock      in   1                      router clock; all state updates on its rising edge
//  i_reset      in   1                      synchronous, active-high reset
//  i_rx         in   1                      incoming flit valid from link
//  i_data_in    in   FLIT_WIDTH             incoming flit
//  o_credit     out  1                      space available; flit accepted only when i_rx && o_credit
//  o_overflow   out  1                      sticky: flit presented while o_credit==0 (cleared only by reset)
//  o_h          out  1                      header request to arbiter
//  i_ack_h      in   1                      header granted (route allocated)
//  o_data_av    out  1                      head flit valid for crossbar
//  o_data       out  FLIT_WIDTH             head flit (first-word-fall-through)
//  i_data_ack   in   1                      crossbar consumed head flit
//  o_sender     out  1                      packet owns an output; high from grant until last flit consumed
//  o_count      out  $clog2(BUFFER_DEPTH)+1 current FIFO occupancy
// BEHAVIOUR
//  Reset: pointers=0, o_count=0, state=S_IDLE, flit counter=0.
//   Outputs: o_h=0, o_data_av=0, o_sender=0, o_overflow=0, o_credit=1.
//   o_data is don't-care while o_data_av=0.
//  Reset asserted at any point, including mid-packet, flushes the FIFO and returns to S_IDLE on that edge.
//  FIFO:
//   - write = i_rx && o_credit; read = i_data_ack && o_data_av.
//   - o_credit = (o_count < BUFFER_DEPTH), computed from the registered count.
//     When full, a write in the same cycle as a read is still rejected.
//   - Simultaneous write+read: count unchanged, both pointers advance.
//   - Pointers wrap modulo BUFFER_DEPTH.
//   - i_rx while o_credit==0: flit dropped, o_overflow<=1.
//  FSM (registered state; o_h = state==S_REQ; o_sender = state in {S_HDR,S_SIZE,S_PAYLOAD}):
//   S_IDLE:    o_count!=0 at edge -> S_REQ. The header is written at edge k, so o_h is high after edge k+1.
//   S_REQ:     hold o_h until i_ack_h sampled high -> S_HDR. i_ack_h ignored in all other states.
//   S_HDR:     o_data_av=(o_count!=0); on read -> S_SIZE.
//   S_SIZE:    o_data_av=(o_count!=0); on read, flit counter <= o_data.
//              If o_data==0 -> S_IDLE, else -> S_PAYLOAD.
//   S_PAYLOAD: o_data_av=(o_count!=0); each read decrements the counter; read at counter==1 -> S_IDLE.
//  o_data_av is combinational from state and o_count. It drops while the FIFO is empty mid-packet (stall);
//   o_sender stays high during the stall.
//  Back-to-back packets: leaving for S_IDLE with the next header already buffered gives S_REQ on the following edge.
//  Size arithmetic: counter is FLIT_WIDTH bits, unsigned; no limit on N beyond its width.
// TESTING
//  1 Reset -> o_h=0, o_data_av=0, o_sender=0, o_overflow=0, o_credit=1, o_count=0.
//  2 Write 0x0011,0x0002,0xAAAA,0xBBBB; ack at first o_h -> o_h rises 1 cycle after header write.
//    Flits then emerge in order; o_sender falls after 0xBBBB is acked.
//  3 Write 16 flits with no ack -> o_credit=0; 17th flit dropped, o_overflow=1.
//    Then drain -> exactly the 16 original flits.
//  4 Size-0 packet (0x0022,0x0000) followed immediately by 0x0033,0x0001,0xCCCC:
//    first packet ends after 2 reads; o_h re-asserts the next cycle.
//  5 Write+read every cycle at o_count=1 for 40 cycles -> o_count stays 1.
//    Pointers wrap twice; data order preserved.
//  6 i_reset high mid-payload (counter=3) -> next cycle o_count=0, o_sender=0, o_h=0.
//    A new packet is then handled normally.

Source files
------------

// File: rtl/noc_input_buffer.sv
// rtl/noc_input_buffer.sv - router input FIFO with header request and packet release FSM
// Flits are buffered first-word-fall-through; a granted packet is released header, size, then N payload flits.

module noc_input_buffer #(
   parameter int FLIT_WIDTH   = 16,
   parameter int BUFFER_DEPTH = 16
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_rx,
   input  logic [FLIT_WIDTH-1:0]         i_data_in,
   output logic                          o_credit,
   output logic                          o_overflow,
   output logic                          o_h,
   input  logic                          i_ack_h,
   output logic                          o_data_av,
   output logic [FLIT_WIDTH-1:0]         o_data,
   input  logic                          i_data_ack,
   output logic                          o_sender,
   output logic [$clog2(BUFFER_DEPTH):0] o_count
);

   localparam int PW = $clog2(BUFFER_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_HDR,
      S_SIZE,
      S_PAYLOAD
   } state_t;

   logic [FLIT_WIDTH-1:0] mem [BUFFER_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic [FLIT_WIDTH-1:0] flit_cnt;
   state_t                state;
   logic                  write;
   logic                  read;
   logic                  releasing;

   assign o_credit  = (count < CW'(BUFFER_DEPTH));
   assign write     = i_rx && o_credit;
   assign releasing = (state == S_HDR) || (state == S_SIZE) || (state == S_PAYLOAD);
   assign o_data_av = releasing && (count != '0);
   assign read      = i_data_ack && o_data_av;
   assign o_data    = mem[rd_ptr];
   assign o_count   = count;

   always_ff @(posedge i_clock) begin
      if (write)
         mem[wr_ptr] <= i_data_in;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (write)
            wr_ptr <= wr_ptr + PW'(1);
         if (read)
            rd_ptr <= rd_ptr + PW'(1);
         case ({write, read})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (i_rx && !o_credit)
            o_overflow <= 1'b1;
      end
   end

   // o_h and o_sender are registered alongside the state they decode.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state    <= S_IDLE;
         flit_cnt <= '0;
         o_h      <= 1'b0;
         o_sender <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  state <= S_REQ;
                  o_h   <= 1'b1;
               end
            end
            S_REQ: begin
               if (i_ack_h) begin
                  state    <= S_HDR;
                  o_h      <= 1'b0;
                  o_sender <= 1'b1;
               end
            end
            S_HDR: begin
               if (read)
                  state <= S_SIZE;
            end
            S_SIZE: begin
               if (read) begin
                  flit_cnt <= o_data;
                  if (o_data == '0) begin
                     state    <= S_IDLE;
                     o_sender <= 1'b0;
                  end else begin
                     state <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (read) begin
                  flit_cnt <= flit_cnt - FLIT_WIDTH'(1);
                  if (flit_cnt == FLIT_WIDTH'(1)) begin
                     state    <= S_IDLE;
                     o_sender <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= S_IDLE;
               o_h      <= 1'b0;
               o_sender <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_noc_input_buffer.sv
// tb/tb_noc_input_buffer.sv - directed self-checking bench for noc_input_buffer

module tb_noc_input_buffer;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_rx = 1'b0;
   logic [15:0] i_data_in = '0;
   logic        o_credit;
   logic        o_overflow;
   logic        o_h;
   logic        i_ack_h = 1'b0;
   logic        o_data_av;
   logic [15:0] o_data;
   logic        i_data_ack = 1'b0;
   logic        o_sender;
   logic [4:0]  o_count;

   int total = 0;
   int bad   = 0;

   noc_input_buffer #(.FLIT_WIDTH(16), .BUFFER_DEPTH(16)) dut (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_rx       (i_rx),
      .i_data_in  (i_data_in),
      .o_credit   (o_credit),
      .o_overflow (o_overflow),
      .o_h        (o_h),
      .i_ack_h    (i_ack_h),
      .o_data_av  (o_data_av),
      .o_data     (o_data),
      .i_data_ack (i_data_ack),
      .o_sender   (o_sender),
      .o_count    (o_count)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic send(input logic [15:0] f);
      i_rx      = 1'b1;
      i_data_in = f;
      tick();
      i_rx      = 1'b0;
   endtask

   task automatic grant();
      i_ack_h = 1'b1;
      tick();
      i_ack_h = 1'b0;
   endtask

   task automatic take(input string tag, input logic [15:0] exp);
      chk({tag, "_av"}, 32'(o_data_av), 32'd1);
      chk({tag, "_data"}, 32'(o_data), 32'(exp));
      i_data_ack = 1'b1;
      tick();
      i_data_ack = 1'b0;
   endtask

   task automatic idle_check(input string tag);
      chk({tag, "_sender"}, 32'(o_sender), 32'd0);
      chk({tag, "_count"}, 32'(o_count), 32'd0);
      chk({tag, "_av"}, 32'(o_data_av), 32'd0);
   endtask

   initial begin
      logic [15:0] p [0:40];

      // 1: reset state
      tick();
      tick();
      i_reset = 1'b0;
      chk("rst_h", 32'(o_h), 32'd0);
      chk("rst_av", 32'(o_data_av), 32'd0);
      chk("rst_sender", 32'(o_sender), 32'd0);
      chk("rst_ovf", 32'(o_overflow), 32'd0);
      chk("rst_credit", 32'(o_credit), 32'd1);
      chk("rst_count", 32'(o_count), 32'd0);

      // 2: basic packet, o_h one cycle after header write
      send(16'h0011);
      chk("t2_h_early", 32'(o_h), 32'd0);
      send(16'h0002);
      chk("t2_h_rise", 32'(o_h), 32'd1);
      chk("t2_sender_pre", 32'(o_sender), 32'd0);
      i_ack_h = 1'b1;
      send(16'hAAAA);
      i_ack_h = 1'b0;
      chk("t2_h_fall", 32'(o_h), 32'd0);
      chk("t2_sender", 32'(o_sender), 32'd1);
      send(16'hBBBB);
      chk("t2_count4", 32'(o_count), 32'd4);
      take("t2_f0", 16'h0011);
      take("t2_f1", 16'h0002);
      take("t2_f2", 16'hAAAA);
      chk("t2_sender_mid", 32'(o_sender), 32'd1);
      take("t2_f3", 16'hBBBB);
      idle_check("t2_end");
      chk("t2_h_end", 32'(o_h), 32'd0);

      // 3: fill to full, overflow, drain exactly 16
      p[0] = 16'h0044;
      p[1] = 16'h000E;
      for (int i = 2; i < 16; i++) p[i] = 16'h5000 + 16'(i);
      for (int i = 0; i < 16; i++) send(p[i]);
      chk("t3_full_count", 32'(o_count), 32'd16);
      chk("t3_credit0", 32'(o_credit), 32'd0);
      chk("t3_ovf_pre", 32'(o_overflow), 32'd0);
      send(16'hDEAD);
      chk("t3_ovf", 32'(o_overflow), 32'd1);
      chk("t3_count_keep", 32'(o_count), 32'd16);
      // a read in the same cycle as a write while full must not let the write in
      grant();
      i_rx = 1'b1;
      i_data_in = 16'hBEEF;
      take("t3_d0", p[0]);
      i_rx = 1'b0;
      chk("t3_rw_full", 32'(o_count), 32'd15);
      for (int i = 1; i < 16; i++) take($sformatf("t3_d%0d", i), p[i]);
      idle_check("t3_end");
      chk("t3_credit1", 32'(o_credit), 32'd1);
      chk("t3_ovf_sticky", 32'(o_overflow), 32'd1);

      // 4: size-0 packet then back-to-back packet
      send(16'h0022);
      send(16'h0000);
      send(16'h0033);
      send(16'h0001);
      send(16'hCCCC);
      chk("t4_h", 32'(o_h), 32'd1);
      grant();
      take("t4_a0", 16'h0022);
      take("t4_a1", 16'h0000);
      chk("t4_sender_off", 32'(o_sender), 32'd0);
      chk("t4_h_off", 32'(o_h), 32'd0);
      tick();
      chk("t4_h_again", 32'(o_h), 32'd1);
      grant();
      take("t4_b0", 16'h0033);
      take("t4_b1", 16'h0001);
      take("t4_b2", 16'hCCCC);
      idle_check("t4_end");

      // 5: streaming at occupancy 1 for 40 cycles (pointers wrap)
      for (int i = 0; i <= 40; i++) p[i] = 16'h7000 + 16'(i * 3);
      send(16'h0055);
      send(16'h0029);
      grant();
      take("t5_hdr", 16'h0055);
      take("t5_size", 16'h0029);
      chk("t5_stall_av", 32'(o_data_av), 32'd0);
      chk("t5_stall_sender", 32'(o_sender), 32'd1);
      send(p[0]);
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("t5_data%0d", i), 32'(o_data), 32'(p[i]));
         i_rx       = 1'b1;
         i_data_in  = p[i+1];
         i_data_ack = 1'b1;
         tick();
         chk($sformatf("t5_count%0d", i), 32'(o_count), 32'd1);
      end
      i_rx       = 1'b0;
      i_data_ack = 1'b0;
      take("t5_last", p[40]);
      idle_check("t5_end");

      // 6: reset mid-payload with counter at 3
      send(16'h0066);
      send(16'h0005);
      for (int i = 0; i < 5; i++) send(16'h6100 + 16'(i));
      grant();
      take("t6_hdr", 16'h0066);
      take("t6_size", 16'h0005);
      take("t6_p0", 16'h6100);
      take("t6_p1", 16'h6101);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      idle_check("t6_rst");
      chk("t6_rst_h", 32'(o_h), 32'd0);
      chk("t6_rst_ovf", 32'(o_overflow), 32'd0);
      send(16'h0077);
      send(16'h0001);
      send(16'hEEEE);
      chk("t6_new_h", 32'(o_h), 32'd1);
      grant();
      take("t6_n0", 16'h0077);
      take("t6_n1", 16'h0001);
      take("t6_n2", 16'hEEEE);
      idle_check("t6_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
